// File: rtl/fifo_wr_arbiter.sv
// -----------------------------------------------------------------------------
// fifo_wr_arbiter
//   Round-robin arbiter that shares the write port of a single synchronous FIFO
//   among NREQ producers. A grant is burst-locked: the owner keeps the port for
//   up to BURST words, and a burst is only started when the FIFO has room for
//   a complete burst. One idle cycle always separates consecutive bursts.
//
// Ports
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   req         per-requester "word valid on din"
//   din         packed data, word i = din[i*WIDTH +: WIDTH]
//   ack         per-requester "word taken this cycle" (combinational)
//   fifo_wr     FIFO write strobe (combinational, never set while fifo_full)
//   fifo_data   FIFO write data, always the word of gnt_id
//   fifo_full   FIFO full flag
//   fifo_usedw  FIFO fill level
//   busy        a burst grant is active (registered)
//   gnt_id      current or most recent owner (registered)
// -----------------------------------------------------------------------------
module fifo_wr_arbiter #(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8,
    parameter int unsigned BURST = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NREQ-1:0]            req,
    input  logic [NREQ*WIDTH-1:0]      din,
    output logic [NREQ-1:0]            ack,
    output logic                       fifo_wr,
    output logic [WIDTH-1:0]           fifo_data,
    input  logic                       fifo_full,
    input  logic [$clog2(DEPTH)-1:0]   fifo_usedw,
    output logic                       busy,
    output logic [$clog2(NREQ)-1:0]    gnt_id
);

    localparam int unsigned IdW   = $clog2(NREQ);
    localparam int unsigned UsedW = $clog2(DEPTH);
    // One extra bit so a count of BURST (== DEPTH allowed) does not wrap.
    localparam int unsigned CntW  = $clog2(BURST) + 1;
    // Free space spans 0..DEPTH, which needs one bit more than usedw.
    localparam int unsigned FreeW = UsedW + 1;

    typedef enum logic [0:0] {
        StIdle,
        StBusy
    } state_e;

    state_e          state_q;
    logic [IdW-1:0]  owner_q;
    logic [IdW-1:0]  last_q;
    logic [CntW-1:0] cnt_q;
    logic            busy_q;

    logic [FreeW-1:0] free_words;
    logic             room;
    logic             win_found;
    logic [IdW-1:0]   win_id;
    logic [IdW-1:0]   cand;
    logic             xfer;
    logic [WIDTH-1:0] words [NREQ];

    // -------------------------------------------------------------------------
    // Free space and burst admission
    // -------------------------------------------------------------------------
    // usedw wraps to 0 when the FIFO is full, so the full flag must win.
    assign free_words = fifo_full ? '0 : (FreeW'(DEPTH) - {1'b0, fifo_usedw});
    assign room       = (free_words >= FreeW'(BURST));

    // -------------------------------------------------------------------------
    // Round-robin winner: first requester after last_q, wrapping modulo NREQ.
    // last_q itself is searched last, so the previous owner has lowest priority.
    // -------------------------------------------------------------------------
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        cand      = '0;
        for (int k = 1; k <= int'(NREQ); k++) begin
            cand = IdW'((int'(last_q) + k) % int'(NREQ));
            if (!win_found && req[cand]) begin
                win_found = 1'b1;
                win_id    = cand;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Data path and handshake
    // -------------------------------------------------------------------------
    always_comb begin
        for (int i = 0; i < int'(NREQ); i++) begin
            words[i] = din[i*WIDTH +: WIDTH];
        end
    end

    assign fifo_data = words[owner_q];

    // A stalled (full) FIFO simply withholds the transfer; the burst stays open.
    assign xfer = (state_q == StBusy) && req[owner_q] && !fifo_full;

    always_comb begin
        ack = '0;
        if (xfer) begin
            ack[owner_q] = 1'b1;
        end
    end

    assign fifo_wr = xfer;
    assign busy    = busy_q;
    assign gnt_id  = owner_q;

    // -------------------------------------------------------------------------
    // Grant FSM with registered busy / gnt_id
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
            owner_q <= '0;
            // Pointer starts at the top so requester 0 wins the first grant.
            last_q  <= IdW'(NREQ - 1);
            cnt_q   <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    // Grant cycle: no ack yet, the owner is served from the next cycle.
                    if (win_found && room) begin
                        owner_q <= win_id;
                        busy_q  <= 1'b1;
                        cnt_q   <= '0;
                        state_q <= StBusy;
                    end
                end
                StBusy: begin
                    if (!req[owner_q]) begin
                        // Owner withdrew: close the burst but still rotate priority.
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                        last_q  <= owner_q;
                    end else if (xfer) begin
                        cnt_q <= cnt_q + 1'b1;
                        if (cnt_q == CntW'(BURST - 1)) begin
                            state_q <= StIdle;
                            busy_q  <= 1'b0;
                            last_q  <= owner_q;
                        end
                    end
                end
                default: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Invariants
    // -------------------------------------------------------------------------
    a_no_write_when_full : assert property (@(posedge clk) disable iff (!rst_n)
        !(fifo_wr && fifo_full));
    a_single_ack : assert property (@(posedge clk) disable iff (!rst_n)
        $onehot0(ack));
    a_ack_matches_write : assert property (@(posedge clk) disable iff (!rst_n)
        ((|ack) == fifo_wr));

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_fifo_wr_arbiter
//   Drives fifo_wr_arbiter with directed and randomized requesters plus a
//   queue-based FIFO model, and compares every cycle against a behavioural
//   model of the arbitration rules. A few literal expectations pin the model.
// -----------------------------------------------------------------------------
module tb_fifo_wr_arbiter;

    localparam int NREQ  = 4;
    localparam int WIDTH = 8;
    localparam int DEPTH = 8;
    localparam int BURST = 4;
    localparam int UW    = $clog2(DEPTH);
    localparam int IW    = $clog2(NREQ);

    logic                  clk;
    logic                  rst_n;
    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] din;
    logic [NREQ-1:0]       ack;
    logic                  fifo_wr;
    logic [WIDTH-1:0]      fifo_data;
    logic                  fifo_full;
    logic [UW-1:0]         fifo_usedw;
    logic                  busy;
    logic [IW-1:0]         gnt_id;

    fifo_wr_arbiter #(
        .NREQ  (NREQ),
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .BURST (BURST)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .din        (din),
        .ack        (ack),
        .fifo_wr    (fifo_wr),
        .fifo_data  (fifo_data),
        .fifo_full  (fifo_full),
        .fifo_usedw (fifo_usedw),
        .busy       (busy),
        .gnt_id     (gnt_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    bit               m_busy;
    int               m_owner;
    int               m_last;
    int               m_cnt;
    logic [WIDTH-1:0] fq [$];
    bit               rq [NREQ];
    logic [WIDTH-1:0] rw [NREQ];
    int               glog [$];
    bit               busy_trace [$];
    int               ack_total;
    int               ack_cnt [NREQ];

    // Stimulus knobs
    int fixed_mask = -1;
    int p_req      = 0;
    int p_drop     = 0;
    int p_read     = 0;
    int p_force    = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle: entered and left at posedge+1.
    task automatic do_cycle();
        bit               force_f;
        bit               full_m;
        int               free_sp;
        bit               xfer;
        logic [NREQ-1:0]  e_ack;
        bit               was_busy;
        int               was_owner;
        bit               found;

        force_f = ($urandom_range(99) < p_force);
        full_m  = (fq.size() == DEPTH) || force_f;
        for (int i = 0; i < NREQ; i++) begin
            req[i]                = rq[i];
            din[i*WIDTH +: WIDTH] = rw[i];
        end
        fifo_full  = full_m;
        fifo_usedw = UW'(fq.size());

        #4;
        free_sp = full_m ? 0 : DEPTH - fq.size();
        e_ack   = '0;
        xfer    = 1'b0;
        if (m_busy) begin
            xfer = rq[m_owner] && !full_m;
            if (xfer) e_ack[m_owner] = 1'b1;
        end
        check("ack", 64'(ack), 64'(e_ack));
        check("fifo_wr", 64'(fifo_wr), 64'(xfer));
        check("busy", 64'(busy), 64'(m_busy));
        check("gnt_id", 64'(gnt_id), 64'(m_owner));
        if (xfer) check("fifo_data", 64'(fifo_data), 64'(rw[m_owner]));
        busy_trace.push_back(busy);
        ack_total += $countones(ack);
        for (int i = 0; i < NREQ; i++) ack_cnt[i] += int'(ack[i]);

        // Arbitration rules
        was_busy  = m_busy;
        was_owner = m_owner;
        if (!m_busy) begin
            found = 1'b0;
            if (free_sp >= BURST) begin
                for (int k = 1; k <= NREQ; k++) begin
                    int idx;
                    idx = (m_last + k) % NREQ;
                    if (!found && rq[idx]) begin
                        found   = 1'b1;
                        m_busy  = 1'b1;
                        m_owner = idx;
                        m_cnt   = 0;
                        glog.push_back(idx);
                    end
                end
            end
        end else if (xfer) begin
            m_cnt++;
            if (m_cnt == BURST) begin
                m_busy = 1'b0;
                m_last = m_owner;
            end
        end else if (!rq[m_owner]) begin
            m_busy = 1'b0;
            m_last = m_owner;
        end

        // External FIFO: optional read, then the write
        if (fq.size() > 0 && $urandom_range(99) < p_read) void'(fq.pop_front());
        if (xfer) fq.push_back(rw[was_owner]);

        // Requesters
        for (int i = 0; i < NREQ; i++) begin
            if (fixed_mask >= 0) begin
                if (e_ack[i] || !rq[i]) rw[i] = WIDTH'($urandom);
                rq[i] = fixed_mask[i];
            end else if (e_ack[i]) begin
                rw[i] = WIDTH'($urandom);
                rq[i] = ($urandom_range(99) < p_req);
            end else if (!rq[i]) begin
                rq[i] = ($urandom_range(99) < p_req);
                if (rq[i]) rw[i] = WIDTH'($urandom);
            end else if (was_busy && i == was_owner && $urandom_range(99) < p_drop) begin
                rq[i] = 1'b0;
            end
        end

        @(posedge clk);
        #1;
    endtask

    // Asynchronous reset in the middle of a cycle; entered and left at posedge+1.
    task automatic do_reset_mid();
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_ack", 64'(ack), 64'(0));
        check("rst_fifo_wr", 64'(fifo_wr), 64'(0));
        check("rst_gnt_id", 64'(gnt_id), 64'(0));
        m_busy  = 1'b0;
        m_owner = 0;
        m_last  = NREQ - 1;
        m_cnt   = 0;
        fq.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        int exp_t1 [12];
        int exp_t2 [5];
        int first_busy;
        int a0;
        int a3;
        int rd_pct [4];

        exp_t1 = '{0, 1, 1, 1, 1, 0, 1, 1, 1, 1, 0, 0};
        exp_t2 = '{0, 1, 2, 3, 0};
        rd_pct = '{15, 40, 70, 100};

        rst_n      = 1'b0;
        req        = '0;
        din        = '0;
        fifo_full  = 1'b0;
        fifo_usedw = '0;
        m_busy     = 1'b0;
        m_owner    = 0;
        m_last     = NREQ - 1;
        m_cnt      = 0;
        ack_total  = 0;
        for (int i = 0; i < NREQ; i++) begin
            rq[i]      = 1'b0;
            rw[i]      = WIDTH'($urandom);
            ack_cnt[i] = 0;
        end

        // Reset values
        #12;
        check("reset_busy", 64'(busy), 64'(0));
        check("reset_gnt_id", 64'(gnt_id), 64'(0));
        check("reset_ack", 64'(ack), 64'(0));
        check("reset_fifo_wr", 64'(fifo_wr), 64'(0));

        // Single requester, no reads: two back-to-back bursts fill the FIFO
        fixed_mask = 1;
        rq[0]      = 1'b1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        busy_trace.delete();
        repeat (12) do_cycle();
        for (int i = 0; i < 12; i++) check("t1_busy_trace", 64'(busy_trace[i]), 64'(exp_t1[i]));
        check("t1_ack_total", 64'(ack_total), 64'(8));
        check("t1_fifo_level", 64'(fq.size()), 64'(8));

        // Drain one word per cycle: no grant until free space reaches BURST
        p_read = 100;
        busy_trace.delete();
        repeat (7) do_cycle();
        first_busy = -1;
        for (int i = 6; i >= 0; i--) if (busy_trace[i]) first_busy = i;
        check("t4_first_grant_cycle", 64'(first_busy), 64'(5));

        // Reset in the middle of a burst
        check("t6_busy_before_reset", 64'(busy), 64'(1));
        do_reset_mid();

        // All requesting, FIFO drained every cycle: strict rotation from 0
        fixed_mask = 15;
        for (int i = 0; i < NREQ; i++) rq[i] = 1'b1;
        glog.delete();
        repeat (30) do_cycle();
        for (int i = 0; i < 5; i++) check("t2_grant_order", 64'(glog[i]), 64'(exp_t2[i]));

        // Requesters 1 and 2 only, last owner was 1: 2 wins, then 1
        check("t3_last_owner", 64'(m_last), 64'(1));
        fixed_mask = 6;
        for (int i = 0; i < NREQ; i++) rq[i] = fixed_mask[i];
        glog.delete();
        a0 = ack_cnt[0];
        a3 = ack_cnt[3];
        repeat (12) do_cycle();
        check("t3_first_grant", 64'(glog[0]), 64'(2));
        check("t3_second_grant", 64'(glog[1]), 64'(1));
        check("t3_no_ack_0", 64'(ack_cnt[0] - a0), 64'(0));
        check("t3_no_ack_3", 64'(ack_cnt[3] - a3), 64'(0));

        // Randomized traffic: drops, forced full stalls, varying drain rates
        fixed_mask = -1;
        p_req      = 60;
        p_drop     = 5;
        p_force    = 10;
        for (int ph = 0; ph < 4; ph++) begin
            p_read = rd_pct[ph];
            repeat (800) do_cycle();
            if (m_busy) do_reset_mid();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
